// File: rtl/mpe_pkg.sv
// Shared types and helpers for the multiphase enable sequencer.
package mpe_pkg;

  // Sequencer states: waiting for start, driving a phase enable, or in the quiet gap after a phase.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Phase counts are handled in a 5-bit container so that NUM_PHASES up to 16 fits.
  localparam int PHASE_REQ_W = 5;

  // Requests of zero or beyond the maximum fall back to the full phase count.
  function automatic logic [PHASE_REQ_W-1:0] clamp_phases(
    input logic [PHASE_REQ_W-1:0] req,
    input logic [PHASE_REQ_W-1:0] max_phases
  );
    if (req == '0 || req > max_phases) begin
      return max_phases;
    end
    return req;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times phase widths and inter-phase gaps.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/multiphase_enable_seq.sv
// Generates non-overlapping one-hot phase enables from a single clock.
// Downstream stages use these as clock enables instead of multiphase clocks.
module multiphase_enable_seq
  import mpe_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_W-1:0]      cfg_width,
  input  logic [CNT_W-1:0]      cfg_gap,
  input  logic [IDX_W:0]        cfg_phases,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  round_done,
  output logic                  busy
);

  localparam logic [PHASE_REQ_W-1:0] MAX_PHASES = PHASE_REQ_W'(NUM_PHASES);

  state_t           state;
  logic             stop_pend;

  // Config captured at start so mid-run changes on the cfg inputs are ignored.
  logic [CNT_W-1:0] width_m1_s;
  logic [CNT_W-1:0] gap_s;
  logic [IDX_W-1:0] last_idx_s;

  // Config as it would be captured this cycle, used when leaving IDLE.
  logic [CNT_W-1:0]       cfg_width_m1;
  logic [PHASE_REQ_W-1:0] cfg_eff_phases;
  logic [IDX_W-1:0]       cfg_last_idx;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_zero;

  state_t           nxt_state;
  logic [IDX_W-1:0] nxt_idx;
  logic [CNT_W-1:0] nxt_cnt;
  logic [IDX_W-1:0] nxt_last_idx;
  logic [CNT_W-1:0] nxt_gap;
  logic             nxt_round_last;
  logic             stop_req;

  assign cfg_width_m1   = (cfg_width == '0) ? '0 : cfg_width - CNT_W'(1);
  assign cfg_eff_phases = clamp_phases(PHASE_REQ_W'(cfg_phases), MAX_PHASES);
  assign cfg_last_idx   = IDX_W'(cfg_eff_phases - PHASE_REQ_W'(1));
  assign stop_req       = stop_pend | stop;

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .en      (tmr_en),
    .count   (tmr_count),
    .zero    (tmr_zero)
  );

  // Next-state decision plus a look-ahead of the timer so that round_done can be
  // registered into the exact cycle that closes the round.
  always_comb begin
    nxt_state      = state;
    nxt_idx        = phase_idx;
    tmr_load       = 1'b0;
    tmr_load_val   = '0;
    tmr_en         = 1'b0;
    nxt_last_idx   = last_idx_s;
    nxt_gap        = gap_s;
    nxt_round_last = 1'b0;

    case (state)
      IDLE: begin
        nxt_last_idx = cfg_last_idx;
        nxt_gap      = cfg_gap;
        if (start && !stop) begin
          nxt_state    = ACTIVE;
          nxt_idx      = '0;
          tmr_load     = 1'b1;
          tmr_load_val = cfg_width_m1;
        end
      end
      ACTIVE, GAP: begin
        if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else if (state == ACTIVE && gap_s != '0) begin
          nxt_state    = GAP;
          tmr_load     = 1'b1;
          tmr_load_val = gap_s - CNT_W'(1);
        end else if (phase_idx == last_idx_s) begin
          if (stop_req) begin
            nxt_state = IDLE;
          end else begin
            nxt_state    = ACTIVE;
            nxt_idx      = '0;
            tmr_load     = 1'b1;
            tmr_load_val = width_m1_s;
          end
        end else begin
          nxt_state    = ACTIVE;
          nxt_idx      = phase_idx + IDX_W'(1);
          tmr_load     = 1'b1;
          tmr_load_val = width_m1_s;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase

    if (tmr_load) begin
      nxt_cnt = tmr_load_val;
    end else if (tmr_en) begin
      nxt_cnt = tmr_count - CNT_W'(1);
    end else begin
      nxt_cnt = tmr_count;
    end

    if (nxt_state != IDLE && nxt_cnt == '0 && nxt_idx == nxt_last_idx &&
        (nxt_state == GAP || nxt_gap == '0)) begin
      nxt_round_last = 1'b1;
    end
  end

  // FSM state, shadow config and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      stop_pend  <= 1'b0;
      phase_en   <= '0;
      phase_idx  <= '0;
      round_done <= 1'b0;
      busy       <= 1'b0;
      width_m1_s <= '0;
      gap_s      <= '0;
      last_idx_s <= '0;
    end else begin
      state      <= nxt_state;
      phase_idx  <= nxt_idx;
      phase_en   <= (nxt_state == ACTIVE) ? (NUM_PHASES'(1) << nxt_idx) : '0;
      busy       <= (nxt_state != IDLE);
      round_done <= nxt_round_last;
      if (nxt_state == IDLE) begin
        stop_pend <= 1'b0;
      end else if (state != IDLE && stop) begin
        stop_pend <= 1'b1;
      end
      if (state == IDLE && nxt_state == ACTIVE) begin
        width_m1_s <= cfg_width_m1;
        gap_s      <= cfg_gap;
        last_idx_s <= cfg_last_idx;
      end
    end
  end

endmodule
